// File: rtl/mole_target_ctrl.sv
// mole_target_ctrl: whack-a-mole round controller (gap, lit target, hit/miss, saturating score).
// Define NO_REPEAT_EN to forbid the same target position twice in a row.
module mole_target_ctrl #(
    parameter int NUM_POS     = 18,
    parameter int LIFE_CYCLES = 50_000_000,
    parameter int GAP_CYCLES  = 10_000_000,
    parameter int SCORE_W     = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic [4:0]         random_pos,
    input  logic [NUM_POS-1:0] sw,
    output logic [NUM_POS-1:0] led,
    output logic               hit_pulse,
    output logic               miss_pulse,
    output logic [SCORE_W-1:0] score,
    output logic               active
);
    localparam int TW = $clog2(LIFE_CYCLES > GAP_CYCLES ? LIFE_CYCLES : GAP_CYCLES);
    typedef enum logic [1:0] {IDLE, GAP, SAMPLE, SHOW} state_t;
    state_t             state;
    logic [TW-1:0]      timer;
    logic [NUM_POS-1:0] sw_q;
    logic               enable_q;
    logic               pos_ok;
    logic               hit;
`ifdef NO_REPEAT_EN
    logic [4:0]         prev_pos;
    assign pos_ok = int'(random_pos) < NUM_POS && random_pos != prev_pos;
`else
    assign pos_ok = int'(random_pos) < NUM_POS;
`endif
    // led carries the one-hot target throughout SHOW, so it also selects the switch to watch
    assign hit = |(sw & ~sw_q & led);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            timer      <= '0;
            sw_q       <= '0;
            enable_q   <= 1'b0;
            led        <= '0;
            hit_pulse  <= 1'b0;
            miss_pulse <= 1'b0;
            score      <= '0;
            active     <= 1'b0;
`ifdef NO_REPEAT_EN
            prev_pos   <= 5'(NUM_POS);
`endif
        end else begin
            sw_q       <= sw;
            enable_q   <= enable;
            hit_pulse  <= 1'b0;
            miss_pulse <= 1'b0;
            if (!enable) begin
                state  <= IDLE;
                led    <= '0;
                active <= 1'b0;
                timer  <= '0;
            end else begin
                case (state)
                    IDLE: if (!enable_q) begin
                        score <= '0;
                        timer <= '0;
                        state <= GAP;
`ifdef NO_REPEAT_EN
                        prev_pos <= 5'(NUM_POS);
`endif
                    end
                    GAP: begin
                        timer <= timer + 1'b1;
                        if (timer == TW'(GAP_CYCLES - 1)) begin
                            timer <= '0;
                            state <= SAMPLE;
                        end
                    end
                    SAMPLE: if (pos_ok) begin
                        led    <= NUM_POS'(1) << random_pos;
                        active <= 1'b1;
                        timer  <= '0;
                        state  <= SHOW;
`ifdef NO_REPEAT_EN
                        prev_pos <= random_pos;
`endif
                    end
                    SHOW: begin
                        timer <= timer + 1'b1;
                        if (hit || timer == TW'(LIFE_CYCLES - 1)) begin
                            hit_pulse  <= hit;
                            miss_pulse <= !hit;
                            led        <= '0;
                            active     <= 1'b0;
                            timer      <= '0;
                            state      <= GAP;
                            if (hit && !(&score)) score <= score + 1'b1;
                        end
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_mole_target_ctrl.sv
// tb_mole_target_ctrl: randomized scenario bench with a countdown-style game model.
module tb_mole_target_ctrl;
    localparam int NP = 18, LIFE = 8, GAP = 4, SW = 4;
    localparam int SMAX = (1 << SW) - 1;
`ifdef NO_REPEAT_EN
    localparam bit NOREP = 1'b1;
`else
    localparam bit NOREP = 1'b0;
`endif
    logic          clk = 1'b0, rst_n = 1'b0, enable = 1'b0;
    logic [4:0]    random_pos = '0;
    logic [NP-1:0] sw = '0;
    logic [NP-1:0] led;
    logic          hit_pulse, miss_pulse, active;
    logic [SW-1:0] score;
    logic [24:0]   dut_out, m_out;
    int            m_lit, m_gap, m_age, m_last, m_score;
    bit            m_run, m_seek, m_hit, m_miss, m_en_prev;
    logic [NP-1:0] m_sw_prev;
    int            n_checks = 0, n_pass = 0;

    mole_target_ctrl #(.NUM_POS(NP), .LIFE_CYCLES(LIFE), .GAP_CYCLES(GAP), .SCORE_W(SW)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .random_pos(random_pos), .sw(sw),
        .led(led), .hit_pulse(hit_pulse), .miss_pulse(miss_pulse), .score(score), .active(active)
    );

    always #5 clk = ~clk;
    assign dut_out = {led, hit_pulse, miss_pulse, score, active};

    task automatic model_out;
        m_out = {m_lit >= 0 ? NP'(1) << m_lit : NP'(0), m_hit, m_miss, SW'(m_score), m_lit >= 0};
    endtask

    task automatic model_reset;
        m_lit = -1; m_gap = 0; m_age = 0; m_last = NP; m_score = 0;
        m_run = 0; m_seek = 0; m_hit = 0; m_miss = 0; m_en_prev = 0; m_sw_prev = '0;
        model_out();
    endtask

    // Game rules: gap countdown, hunt for an acceptable position, then a lit target ages out
    task automatic model_step;
        m_hit = 0; m_miss = 0;
        if (!enable) begin
            m_run = 0; m_seek = 0; m_lit = -1; m_gap = 0;
        end else if (!m_run) begin
            if (!m_en_prev) begin m_run = 1; m_score = 0; m_gap = GAP; m_last = NP; end
        end else if (m_gap > 0) begin
            m_gap--;
            m_seek = (m_gap == 0);
        end else if (m_seek) begin
            if (random_pos < NP && !(NOREP && random_pos == m_last)) begin
                m_lit = random_pos; m_last = random_pos; m_age = 0; m_seek = 0;
            end
        end else if (m_lit >= 0) begin
            m_age++;
            if (sw[m_lit] && !m_sw_prev[m_lit]) begin
                m_hit = 1; m_score = (m_score == SMAX) ? SMAX : m_score + 1; m_lit = -1; m_gap = GAP;
            end else if (m_age == LIFE) begin
                m_miss = 1; m_lit = -1; m_gap = GAP;
            end
        end
        m_sw_prev = sw; m_en_prev = enable;
        model_out();
    endtask

    task automatic tick;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset;
        model_reset();
        #12;
        n_checks++; if (dut_out !== '0) $display("FAIL reset_hold got=%h want=0", dut_out); else n_pass++;
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            n_checks++; if (dut_out !== '0) $display("FAIL idle_quiet cyc=%0d got=%h want=0", i, dut_out); else n_pass++;
        end
    endtask

    task automatic test_first_hit;
        enable = 1'b1; random_pos = 5'd5;
        for (int i = 1; i <= 6; i++) begin
            tick();
            n_checks++; if (led !== (i == 6 ? 18'h00020 : 18'h0)) $display("FAIL first_led cyc=%0d got=%h want=%h", i, led, i == 6 ? 18'h00020 : 18'h0); else n_pass++;
            n_checks++; if (dut_out !== m_out) $display("FAIL first_model cyc=%0d got=%h want=%h", i, dut_out, m_out); else n_pass++;
        end
        tick(); tick();
        sw[5] = 1'b1;
        tick();
        n_checks++; if ({hit_pulse, miss_pulse, score, led} !== {1'b1, 1'b0, 4'd1, 18'h0}) $display("FAIL first_hit got=%b%b %h %h want=10 1 0", hit_pulse, miss_pulse, score, led); else n_pass++;
        tick();
        n_checks++; if (dut_out !== m_out || hit_pulse !== 1'b0) $display("FAIL hit_one_cycle got=%h want=%h", dut_out, m_out); else n_pass++;
    endtask

    task automatic test_miss;
        int lit_at, miss_at;
        sw = '0; random_pos = NOREP ? 5'd6 : 5'd5;
        lit_at = -1; miss_at = -1;
        for (int i = 0; i < 40 && miss_at < 0; i++) begin
            tick();
            n_checks++; if (dut_out !== m_out) $display("FAIL miss_model cyc=%0d got=%h want=%h", i, dut_out, m_out); else n_pass++;
            if (lit_at < 0 && led !== '0) lit_at = i;
            if (miss_pulse === 1'b1) miss_at = i;
        end
        n_checks++; if (lit_at < 0 || miss_at - lit_at != LIFE) $display("FAIL miss_latency got=%0d want=%0d", miss_at - lit_at, LIFE); else n_pass++;
        n_checks++; if (score !== 4'd1) $display("FAIL miss_score got=%0d want=1", score); else n_pass++;
    endtask

    task automatic test_reject;
        random_pos = 5'd20;
        for (int i = 0; i < 20 && !m_seek; i++) tick();
        n_checks++; if (!m_seek) $display("FAIL reject_reach_sample got=0 want=1"); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++; if ({led, active} !== '0) $display("FAIL reject_hold cyc=%0d got=%h want=0", i, led); else n_pass++;
        end
        random_pos = 5'd7;
        tick();
        n_checks++; if (led !== 18'h00080 || active !== 1'b1) $display("FAIL reject_accept got=%h want=00080", led); else n_pass++;
    endtask

    task automatic test_hit_priority;
        for (int i = 0; i < 3; i++) tick();
        sw[3] = 1'b1;
        tick();
        n_checks++; if (dut_out !== m_out || hit_pulse !== 1'b0) $display("FAIL nontarget_edge got=%h want=%h", dut_out, m_out); else n_pass++;
        for (int i = 0; i < 10 && m_age < LIFE - 1; i++) tick();
        sw[7] = 1'b1;
        tick();
        n_checks++; if ({hit_pulse, miss_pulse} !== 2'b10) $display("FAIL hit_on_timeout got=%b%b want=10", hit_pulse, miss_pulse); else n_pass++;
        n_checks++; if (dut_out !== m_out) $display("FAIL hit_on_timeout_model got=%h want=%h", dut_out, m_out); else n_pass++;
        tick();
        n_checks++; if ({hit_pulse, miss_pulse} !== 2'b00) $display("FAIL no_late_miss got=%b%b want=00", hit_pulse, miss_pulse); else n_pass++;
        sw = '0;
    endtask

    task automatic test_saturate;
        for (int r = 0; r < 20; r++) begin
            for (int i = 0; i < 60 && led === '0; i++) begin
                random_pos = 5'($urandom_range(0, 31));
                tick();
                n_checks++; if (dut_out !== m_out) $display("FAIL sat_wait r=%0d got=%h want=%h", r, dut_out, m_out); else n_pass++;
            end
            n_checks++; if (led === '0) $display("FAIL sat_timeout r=%0d got=0 want=lit", r); else n_pass++;
            sw = '0; tick();
            if (m_lit >= 0) sw[m_lit] = 1'b1;
            tick();
            n_checks++; if (dut_out !== m_out) $display("FAIL sat_hit r=%0d got=%h want=%h", r, dut_out, m_out); else n_pass++;
        end
        n_checks++; if (score !== 4'hF) $display("FAIL score_saturate got=%h want=f", score); else n_pass++;
        sw = '0;
    endtask

    task automatic test_no_repeat;
        enable = 1'b0; tick();
        enable = 1'b1; random_pos = 5'd7;
        for (int i = 0; i < 20 && led === '0; i++) tick();
        n_checks++; if (led !== 18'h00080) $display("FAIL norep_first got=%h want=00080", led); else n_pass++;
        tick(); sw[7] = 1'b1; tick();
        n_checks++; if (dut_out !== m_out || hit_pulse !== 1'b1) $display("FAIL norep_hit got=%h want=%h", dut_out, m_out); else n_pass++;
        for (int i = 0; i < 20 && !m_seek; i++) tick();
        if (NOREP) begin
            for (int i = 0; i < 3; i++) begin
                tick();
                n_checks++; if (led !== '0) $display("FAIL norep_hold cyc=%0d got=%h want=0", i, led); else n_pass++;
            end
            random_pos = 5'd9;
            tick();
            n_checks++; if (led !== 18'h00200) $display("FAIL norep_next got=%h want=00200", led); else n_pass++;
        end else begin
            tick();
            n_checks++; if (led !== 18'h00080) $display("FAIL repeat_allowed got=%h want=00080", led); else n_pass++;
        end
        sw = '0;
    endtask

    task automatic test_abort;
        int held;
        for (int i = 0; i < 60 && led === '0; i++) begin
            random_pos = 5'($urandom_range(0, 17));
            tick();
        end
        held = m_score;
        enable = 1'b0;
        tick();
        n_checks++; if ({led, hit_pulse, miss_pulse, active} !== '0 || score !== SW'(held)) $display("FAIL abort got=%h want led0 score=%0d", dut_out, held); else n_pass++;
        for (int i = 0; i < 12; i++) begin
            tick();
            n_checks++; if (dut_out !== m_out || score !== SW'(held)) $display("FAIL abort_idle cyc=%0d got=%h want=%h", i, dut_out, m_out); else n_pass++;
        end
        enable = 1'b1;
        tick();
        n_checks++; if (score !== '0) $display("FAIL rise_clears_score got=%0d want=0", score); else n_pass++;
    endtask

    task automatic test_random;
        for (int i = 0; i < 800; i++) begin
            random_pos = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 3) == 0) sw[$urandom_range(0, NP - 1)] ^= 1'b1;
            if (m_lit >= 0 && $urandom_range(0, 5) == 0) sw[m_lit] ^= 1'b1;
            if ($urandom_range(0, 149) == 0) enable = ~enable;
            else if (!enable && $urandom_range(0, 3) == 0) enable = 1'b1;
            tick();
            n_checks++; if (dut_out !== m_out) $display("FAIL random cyc=%0d got=%h want=%h", i, dut_out, m_out); else n_pass++;
        end
    endtask

    task automatic test_async_reset;
        enable = 1'b1;
        for (int i = 0; i < 60 && led === '0; i++) begin
            random_pos = 5'($urandom_range(0, 17));
            tick();
        end
        n_checks++; if (led === '0) $display("FAIL areset_setup got=0 want=lit"); else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (dut_out !== '0) $display("FAIL async_reset got=%h want=0", dut_out); else n_pass++;
        model_reset();
        enable = 1'b0; sw = '0;
        #3 rst_n = 1'b1;
        tick();
        n_checks++; if (dut_out !== '0 || dut_out !== m_out) $display("FAIL after_reset got=%h want=0", dut_out); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_first_hit();
        test_miss();
        test_reject();
        test_hit_priority();
        test_saturate();
        test_no_repeat();
        test_abort();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
